// File: rtl/i2c_target_regbank.sv
// I2C target front end for an external bank of NUM_REGS 8-bit registers.
// Masked address match, repeated START, pointer auto-increment, open-drain SDA enable.
module i2c_target_regbank #(
   parameter int unsigned NUM_REGS    = 256,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AUTO_INC    = 1,
   parameter logic [7:0]  RD_FILL     = 8'hFF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] target_addr_i,
   input  logic [6:0] target_mask_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic       wr_en_o,
   output logic [7:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic [7:0] rd_addr_o,
   input  logic [7:0] rd_data_i,
   output logic       busy_o,
   output logic       stop_o
);

   typedef enum logic [3:0] {
      IDLE, ADDR, IGNORE, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic [3:0] bit_cnt;
   logic [7:0] rx_shift, tx_q, ptr_q;
   logic       rw_q, nack_q;
   logic       sda_oe_q, wr_en_q, busy_q, stop_q;
   logic [7:0] wr_addr_q, wr_data_q;

   // Edges are taken between the last two synchroniser stages.
   logic scl_now, scl_old, sda_now, sda_old;
   assign scl_now = scl_sync[SYNC_STAGES-2];
   assign scl_old = scl_sync[SYNC_STAGES-1];
   assign sda_now = sda_sync[SYNC_STAGES-2];
   assign sda_old = sda_sync[SYNC_STAGES-1];

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_now & ~scl_old;
   assign scl_fall  = ~scl_now & scl_old;
   assign start_det = ~sda_now & sda_old & scl_now & scl_old;
   assign stop_det  = sda_now & ~sda_old & scl_now & scl_old;

   logic       byte_done, ptr_in_range, addr_match;
   logic [7:0] rx_next, ptr_inc, rd_val;
   assign byte_done    = (bit_cnt == 4'd8);
   assign ptr_in_range = ({1'b0, ptr_q} < 9'(NUM_REGS));
   assign ptr_inc      = (ptr_q == 8'(NUM_REGS - 1)) ? 8'h00 : ptr_q + 8'd1;
   assign rx_next      = {rx_shift[6:0], sda_now};
   assign addr_match   = (((rx_shift[7:1] ^ target_addr_i) & target_mask_i) == 7'd0);
   assign rd_val       = ptr_in_range ? rd_data_i : RD_FILL;

   // NOTE: next-state defaults to the current state before any branch, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = ADDR;
      end else if (stop_det) begin
         state_d = IDLE;
      end else if (scl_fall) begin
         case (state_q)
            ADDR:      if (byte_done) state_d = addr_match ? ADDR_ACK : IGNORE;
            ADDR_ACK:  state_d = rw_q ? RDATA : PTR;
            PTR:       if (byte_done) state_d = PTR_ACK;
            PTR_ACK:   state_d = WDATA;
            WDATA:     if (byte_done) state_d = WDATA_ACK;
            WDATA_ACK: state_d = nack_q ? IGNORE : WDATA;
            RDATA:     if (byte_done) state_d = RDATA_ACK;
            RDATA_ACK: state_d = nack_q ? IGNORE : RDATA;
            default:   state_d = state_q;
         endcase
      end
   end

   // NOTE: synchronisers reset to 1, the idle bus level, so leaving reset never looks like an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_sync <= '1;
         sda_sync <= '1;
         state_q  <= IDLE;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         state_q  <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_cnt   <= 4'd0;
         rx_shift  <= 8'h00;
         tx_q      <= 8'h00;
         ptr_q     <= 8'h00;
         rw_q      <= 1'b0;
         nack_q    <= 1'b0;
         sda_oe_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
         busy_q    <= 1'b0;
         stop_q    <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         stop_q  <= 1'b0;
         if (start_det) begin
            bit_cnt  <= 4'd0;
            sda_oe_q <= 1'b0;
         end else if (stop_det) begin
            bit_cnt  <= 4'd0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            stop_q   <= 1'b1;
         end else if (scl_rise) begin
            case (state_q)
               ADDR, PTR, WDATA, RDATA: begin
                  if (!byte_done) begin
                     rx_shift <= rx_next;
                     bit_cnt  <= bit_cnt + 4'd1;
                     if (state_q == WDATA && bit_cnt == 4'd7 && ptr_in_range) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ptr_q;
                        wr_data_q <= rx_next;
                     end
                  end
               end
               RDATA_ACK: begin
                  nack_q <= sda_now;
                  if (AUTO_INC != 0 && ptr_in_range) ptr_q <= ptr_inc;
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state_q)
               ADDR: begin
                  if (byte_done) begin
                     bit_cnt <= 4'd0;
                     rw_q    <= rx_shift[0];
                     if (addr_match) begin
                        sda_oe_q <= 1'b1;
                        busy_q   <= 1'b1;
                     end
                  end
               end
               ADDR_ACK: begin
                  bit_cnt <= 4'd0;
                  if (rw_q) begin
                     tx_q     <= rd_val;
                     sda_oe_q <= ~rd_val[7];
                  end else begin
                     sda_oe_q <= 1'b0;
                  end
               end
               PTR: begin
                  if (byte_done) begin
                     bit_cnt  <= 4'd0;
                     ptr_q    <= rx_shift;
                     sda_oe_q <= 1'b1;
                  end
               end
               PTR_ACK: sda_oe_q <= 1'b0;
               WDATA: begin
                  if (byte_done) begin
                     bit_cnt  <= 4'd0;
                     nack_q   <= ~ptr_in_range;
                     sda_oe_q <= ptr_in_range;
                  end
               end
               WDATA_ACK: begin
                  sda_oe_q <= 1'b0;
                  if (AUTO_INC != 0 && ptr_in_range) ptr_q <= ptr_inc;
               end
               RDATA: begin
                  if (byte_done) begin
                     bit_cnt  <= 4'd0;
                     sda_oe_q <= 1'b0;
                  end else begin
                     sda_oe_q <= ~tx_q[3'd7 - bit_cnt[2:0]];
                  end
               end
               RDATA_ACK: begin
                  if (!nack_q) begin
                     tx_q     <= rd_val;
                     sda_oe_q <= ~rd_val[7];
                  end else begin
                     sda_oe_q <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_oe_o  = sda_oe_q;
   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign rd_addr_o = ptr_q;
   assign busy_o    = busy_q;
   assign stop_o    = stop_q;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Scoreboard bench: two targets (256 regs @0x40, 16 regs @0x50) on one open-drain bus.
module tb_i2c_target_regbank;

   localparam int Q = 8;  // clocks per quarter SCL period

   typedef struct {
      logic       inst;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      string      name;
      logic [7:0] val;
   } bus_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, scl, sda_drv, sda_line;
   logic [6:0] mask_a;
   logic       sda_oe_a, wr_en_a, busy_a, stop_a;
   logic       sda_oe_b, wr_en_b, busy_b, stop_b;
   logic [7:0] wr_addr_a, wr_data_a, rd_addr_a, rd_data_a;
   logic [7:0] wr_addr_b, wr_data_b, rd_addr_b, rd_data_b;
   logic [7:0] regs_a [256];
   logic [7:0] regs_b [16];

   assign sda_line  = sda_drv & ~sda_oe_a & ~sda_oe_b;
   assign rd_data_a = regs_a[rd_addr_a];
   assign rd_data_b = regs_b[rd_addr_b[3:0]];

   i2c_target_regbank #(.NUM_REGS(256)) dut_a (
      .clk_i(clk), .rst_i(rst), .target_addr_i(7'h40), .target_mask_i(mask_a),
      .scl_i(scl), .sda_i(sda_line), .sda_oe_o(sda_oe_a), .wr_en_o(wr_en_a),
      .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a), .rd_addr_o(rd_addr_a),
      .rd_data_i(rd_data_a), .busy_o(busy_a), .stop_o(stop_a));

   i2c_target_regbank #(.NUM_REGS(16)) dut_b (
      .clk_i(clk), .rst_i(rst), .target_addr_i(7'h50), .target_mask_i(7'h7F),
      .scl_i(scl), .sda_i(sda_line), .sda_oe_o(sda_oe_b), .wr_en_o(wr_en_b),
      .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b), .rd_addr_o(rd_addr_b),
      .rd_data_i(rd_data_b), .busy_o(busy_b), .stop_o(stop_b));

   int   n_checks = 0;
   int   n_pass = 0;
   int   stop_cnt_a = 0;
   logic oe_seen_a = 1'b0;
   wr_t        exp_wr[$];
   bus_t       exp_bus[$];
   logic [7:0] obs_bus[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic expect_wr(input logic inst, input logic [7:0] addr, input logic [7:0] data);
      wr_t e;
      e.inst = inst; e.addr = addr; e.data = data;
      exp_wr.push_back(e);
   endtask

   task automatic expect_bus(input string name, input logic [7:0] val);
      bus_t e;
      e.name = name; e.val = val;
      exp_bus.push_back(e);
   endtask

   task automatic mon_wr(input logic inst, input logic [7:0] addr, input logic [7:0] data);
      wr_t e;
      if (exp_wr.size() == 0) begin
         n_checks++;
         $display("FAIL wr_unexpected: inst %0d got addr 0x%0h data 0x%0h, expected no strobe",
                  inst, addr, data);
      end else begin
         e = exp_wr.pop_front();
         check("wr_strobe", {15'd0, inst, addr, data}, {15'd0, e.inst, e.addr, e.data});
      end
      if (inst) regs_b[addr[3:0]] = data;
      else      regs_a[addr] = data;
   endtask

   // Write-port monitor plus stop/oe tracking, sampled on the falling edge.
   always @(negedge clk) begin
      if (wr_en_a) mon_wr(1'b0, wr_addr_a, wr_data_a);
      if (wr_en_b) mon_wr(1'b1, wr_addr_b, wr_data_b);
      if (stop_a) stop_cnt_a++;
      if (sda_oe_a) oe_seen_a = 1'b1;
   end

   // Bus-side checker: compares whatever the controller observed against queued expectations.
   initial begin
      bus_t       e;
      logic [7:0] o;
      forever begin
         @(negedge clk);
         while (obs_bus.size() > 0) begin
            o = obs_bus.pop_front();
            if (exp_bus.size() == 0) begin
               n_checks++;
               $display("FAIL bus_unexpected: got 0x%0h, expected nothing", o);
            end else begin
               e = exp_bus.pop_front();
               check(e.name, {24'd0, o}, {24'd0, e.val});
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic qwait();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic bus_bit(input logic b, output logic s);
      sda_drv = b; qwait();
      scl = 1'b1;  qwait();
      s = sda_line; qwait();
      scl = 1'b0;  qwait();
   endtask

   task automatic bus_start();
      sda_drv = 1'b1; qwait();
      scl = 1'b1;     qwait();
      sda_drv = 1'b0; qwait();
      scl = 1'b0;     qwait();
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; qwait();
      scl = 1'b1;     qwait();
      sda_drv = 1'b1; qwait();
   endtask

   task automatic write_byte(input logic [7:0] b, input string name, input logic exp_ack);
      logic s;
      expect_bus(name, {7'd0, exp_ack});
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, s);
      obs_bus.push_back({7'd0, s});
   endtask

   task automatic read_byte(input logic ack, input string name, input logic [7:0] exp);
      logic s;
      logic [7:0] d;
      d = 8'h00;
      expect_bus(name, exp);
      for (int i = 0; i < 8; i++) begin
         bus_bit(1'b1, s);
         d = {d[6:0], s};
      end
      bus_bit(ack, s);
      obs_bus.push_back(d);
   endtask

   initial begin
      int   s0;
      logic s;
      rst = 1'b1; scl = 1'b1; sda_drv = 1'b1; mask_a = 7'h7F;
      for (int i = 0; i < 256; i++) regs_a[i] = 8'h00;
      for (int i = 0; i < 16; i++) regs_b[i] = 8'h00;
      regs_a[8'h10] = 8'h11; regs_a[8'h11] = 8'h22; regs_a[8'h12] = 8'h33;
      repeat (5) @(posedge clk);
      #1;
      check("rst_sda_oe", {sda_oe_a, sda_oe_b}, 0);
      check("rst_strobes", {wr_en_a, wr_en_b, stop_a, stop_b, busy_a, busy_b}, 0);
      check("rst_wr_bus", {wr_addr_a, wr_data_a, wr_addr_b, wr_data_b}, 0);
      check("rst_ptr", {rd_addr_a, rd_addr_b}, 0);
      rst = 1'b0;
      qwait();

      // Plain write with auto-increment.
      expect_wr(1'b0, 8'h06, 8'hAA);
      expect_wr(1'b0, 8'h07, 8'h55);
      s0 = stop_cnt_a;
      bus_start();
      write_byte(8'h80, "t1_addr_ack", 1'b0);
      write_byte(8'h06, "t1_ptr_ack", 1'b0);
      write_byte(8'hAA, "t1_d0_ack", 1'b0);
      write_byte(8'h55, "t1_d1_ack", 1'b0);
      check("t1_busy_mid", busy_a, 1);
      bus_stop();
      qwait();
      check("t1_stop_pulses", stop_cnt_a - s0, 1);
      check("t1_busy_after", busy_a, 0);

      // Pointer write, repeated START, three-byte read.
      bus_start();
      write_byte(8'h80, "t2_addr_ack", 1'b0);
      write_byte(8'h10, "t2_ptr_ack", 1'b0);
      bus_start();
      write_byte(8'h81, "t2_raddr_ack", 1'b0);
      read_byte(1'b0, "t2_rd0", 8'h11);
      read_byte(1'b0, "t2_rd1", 8'h22);
      read_byte(1'b1, "t2_rd2", 8'h33);
      bus_stop();
      check("t2_final_ptr", rd_addr_a, 8'h13);

      // Address mismatch, then the same address accepted through the mask.
      oe_seen_a = 1'b0;
      bus_start();
      write_byte(8'h82, "t3_mismatch_nack", 1'b1);
      bus_stop();
      check("t3_no_sda_drive", oe_seen_a, 0);
      mask_a = 7'h7E;
      bus_start();
      write_byte(8'h82, "t3_masked_ack", 1'b0);
      write_byte(8'h05, "t3_ptr_ack", 1'b0);
      bus_stop();
      mask_a = 7'h7F;
      check("t3_ptr", rd_addr_a, 8'h05);

      // 16-register target: wrap, out-of-range NACK, fill byte on read.
      expect_wr(1'b1, 8'h0F, 8'h01);
      expect_wr(1'b1, 8'h00, 8'h02);
      bus_start();
      write_byte(8'hA0, "t4_addr_ack", 1'b0);
      write_byte(8'h0F, "t4_ptr_ack", 1'b0);
      write_byte(8'h01, "t4_d0_ack", 1'b0);
      write_byte(8'h02, "t4_d1_ack", 1'b0);
      bus_stop();
      check("t4_wrapped_ptr", rd_addr_b, 8'h01);
      bus_start();
      write_byte(8'hA0, "t4_addr2_ack", 1'b0);
      write_byte(8'h20, "t4_oor_ptr_ack", 1'b0);
      write_byte(8'h03, "t4_oor_data_nack", 1'b1);
      bus_stop();
      check("t4_oor_ptr_held", rd_addr_b, 8'h20);
      bus_start();
      write_byte(8'hA1, "t4_raddr_ack", 1'b0);
      read_byte(1'b1, "t4_fill", 8'hFF);
      bus_stop();
      check("t4_oor_ptr_after_read", rd_addr_b, 8'h20);

      // STOP during the fourth data bit.
      s0 = stop_cnt_a;
      bus_start();
      write_byte(8'h80, "t5_addr_ack", 1'b0);
      write_byte(8'h30, "t5_ptr_ack", 1'b0);
      bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
      bus_stop();
      qwait();
      check("t5_stop_pulses", stop_cnt_a - s0, 1);
      check("t5_released", {sda_oe_a, busy_a}, 0);
      check("t5_ptr", rd_addr_a, 8'h30);

      // Reset while driving a read bit, then a normal write.
      bus_start();
      write_byte(8'h80, "t6_addr_ack", 1'b0);
      write_byte(8'h10, "t6_ptr_ack", 1'b0);
      bus_start();
      write_byte(8'h81, "t6_raddr_ack", 1'b0);
      check("t6_driving_bit7", sda_oe_a, 1);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_released_by_reset", {sda_oe_a, busy_a}, 0);
      @(negedge clk) rst = 1'b0;
      bus_stop();
      expect_wr(1'b0, 8'h21, 8'h5A);
      bus_start();
      write_byte(8'h80, "t6_post_addr_ack", 1'b0);
      write_byte(8'h21, "t6_post_ptr_ack", 1'b0);
      write_byte(8'h5A, "t6_post_d_ack", 1'b0);
      bus_stop();

      // Sub-clock SCL glitch between samples must not shift a bit.
      expect_wr(1'b0, 8'h40, 8'hB3);
      bus_start();
      write_byte(8'h80, "t7_addr_ack", 1'b0);
      write_byte(8'h40, "t7_ptr_ack", 1'b0);
      bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
      @(posedge clk);
      #3 scl = 1'b1;
      #2 scl = 1'b0;
      bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
      expect_bus("t7_d_ack", 8'h00);
      bus_bit(1'b1, s);
      obs_bus.push_back({7'd0, s});
      bus_stop();

      repeat (4 * Q) @(posedge clk);
      #1;
      check("exp_wr_drained", exp_wr.size(), 0);
      check("exp_bus_drained", exp_bus.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_target_regbank.md
Name: i2c_target_regbank

Overview:
- Parametrised successor to the current I2C target.
- Generic I2C target front end for a register bank with NUM_REGS registers of 8 bits each.
- Features the current target lacks:
  - multi-byte reads with pointer auto-increment
  - repeated START
  - address masking
  - open-drain output enable instead of a tri-stated inout
  - configurable input synchroniser depth
  - NACK on out-of-range register writes
- Sits between the board SCL/SDA pads and the PCA register storage; the register storage stays external.

Parameters:
- NUM_REGS, 256, number of addressable registers; legal range 1..256.
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i; minimum 2.
- AUTO_INC, 1, 1 = the register pointer increments after every data byte (read and write); 0 = the pointer holds.
- RD_FILL, 8'hFF, byte returned when reading a register index >= NUM_REGS.

Ports:
- clk_i  in  1  system clock; all logic is on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- target_addr_i  in  7  address the block responds to.
- target_mask_i  in  7  address compare mask; 1 = bit must match, 0 = don't care.
- scl_i  in  1  raw SCL pad input.
- sda_i  in  1  raw SDA pad input.
- sda_oe_o  out  1  1 = pull SDA low; the pad drives 0 when this is 1, else hi-Z.
- wr_en_o  out  1  one-cycle write strobe.
- wr_addr_o  out  8  write register index.
- wr_data_o  out  8  write data.
- rd_addr_o  out  8  read register index; always equals the current pointer.
- rd_data_i  in  8  read data for rd_addr_o; must be valid within 2 clk_i cycles of rd_addr_o changing.
- busy_o  out  1  1 from an addressed, ACKed START until STOP.
- stop_o  out  1  one-cycle pulse on every detected STOP.

Behaviour:
- Reset values:
  - sda_oe_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, stop_o=0.
  - Register pointer=0; state=IDLE; synchronisers load 1.
- Reset asserted mid-transfer releases SDA on the next clock; the block then waits for a new START.
- Input path and edge detection:
  - Both inputs pass through SYNC_STAGES flops.
  - Edges are detected between the last two synchroniser stages only.
  - SCL rise: sample SDA / advance state. SCL fall: update sda_oe_o one clock later.
- START and STOP detection:
  - START = SDA fall while synced SCL=1.
  - STOP = SDA rise while synced SCL=1.
  - Both have priority over any SCL edge in the same cycle.
  - Either one resets the bit counter.
- STOP from any state: go to IDLE, release SDA, pulse stop_o, clear busy_o.
- START from any state, including repeated START mid-byte: go to ADDR. The pointer is retained.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7 address bits, then R/W).
    - Match = ((addr ^ target_addr_i) & target_mask_i) == 0.
    - Match → ADDR_ACK. No match → IGNORE.
  - IGNORE: never drive SDA; wait for START or STOP.
  - ADDR_ACK: drive low for the 9th clock; set busy_o.
    - Write → PTR.
    - Read → load rd_data_i (or RD_FILL) into the TX shift register at the SCL fall ending the ACK, then → RDATA.
  - PTR: shift 8 bits into the pointer → PTR_ACK, which always ACKs.
  - WDATA, entered after PTR_ACK or WDATA_ACK: shift 8 bits.
    - On the 8th SCL rise, pointer < NUM_REGS: wr_en_o pulses one clock later, with wr_addr_o=pointer and wr_data_o=byte; ACK.
    - Pointer >= NUM_REGS: no strobe; NACK (SDA released in the ACK slot).
    - After the ACK slot the pointer increments if AUTO_INC.
  - WDATA_ACK:
    - ACK → back to WDATA.
    - NACK → IGNORE.
  - RDATA: drive the TX bit MSB first. For each bit, sda_oe_o = ~bit, set on the SCL fall.
  - RDATA_ACK: release SDA and sample the controller bit on the SCL rise.
    - ACK (0) → increment the pointer if AUTO_INC, load the next byte at the SCL fall, → RDATA.
    - NACK (1) → IGNORE, pointer still incremented if AUTO_INC.
- Pointer arithmetic:
  - 8 bits; increments wrap to 0 after NUM_REGS-1.
  - A pointer written out of range stays out of range until rewritten; it never auto-increments into range.
- sda_oe_o is only asserted in the ACK slots (ADDR_ACK, PTR_ACK, WDATA_ACK) or in RDATA.

Test Plan:
- Write to matching address 0x40: START, 0x80, ptr 0x06, data 0xAA, 0x55, STOP (AUTO_INC=1) → addr/ptr/data ACKed; wr_en_o pulses (0x06,0xAA) then (0x07,0x55); stop_o one pulse; busy_o low after STOP.
- Combined write/read: write ptr 0x10, repeated START, 0x81, read 3 bytes (ACK, ACK, NACK) with regs 0x10..0x12 = 0x11, 0x22, 0x33 → SDA carries 0x11, 0x22, 0x33; final pointer 0x13; no wr_en_o pulse.
- Mismatch and masking: address 0x41 with mask 7'h7F → no ACK, sda_oe_o never 1. Same address with mask 7'h7E → ACKed.
- Boundary with NUM_REGS=16: write ptr 0x0F, data 0x01, 0x02 → first byte strobed to 0x0F; pointer wraps; second byte strobed to 0x00. Then write ptr 0x20, data 0x03 → NACK, no strobe. Read at ptr 0x20 → 0xFF.
- Abort cases:
  - STOP in the middle of data bit 4 → no strobe, SDA released, stop_o pulses.
  - rst_i asserted during RDATA with sda_oe_o=1 → sda_oe_o=0 the next cycle; the next transaction then works normally.
- Glitch on SCL shorter than SYNC_STAGES clocks, between sampled levels → no bit advance, shift contents unchanged.
